// File: rtl/strobe_decoder_pkg.sv
// Shared types, mode constants and the one-hot helper for strobe_decoder.
package strobe_decoder_pkg;

  // Decoder operating state.
  typedef enum logic {
    ST_WRITE = 1'b0,
    ST_SCAN  = 1'b1
  } dec_state_e;

  // Encoding of the mode input.
  localparam logic MODE_WRITE = 1'b0;
  localparam logic MODE_SCAN  = 1'b1;

  // Widest select vector the helper can build; callers truncate to OUT_N.
  localparam int ONEHOT_MAX   = 1024;
  localparam int ONEHOT_IDX_W = 10;

  // One-hot vector with bit 'index' set, or all zero when index >= width.
  function automatic logic [ONEHOT_MAX-1:0] onehot(input logic [ONEHOT_IDX_W-1:0] index,
                                                   input int width);
    logic [ONEHOT_MAX-1:0] v;
    v = '0;
    if (int'(index) < width) begin
      v[index] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/strobe_decoder_if.sv
// Request/strobe bundle between the stopwatch control logic and strobe_decoder.
interface strobe_decoder_if #(
  parameter int ADDR_W = 4,
  parameter int OUT_N  = 16
);
  logic              mode;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_ack;
  logic              wr_err;
  logic [OUT_N-1:0]  sel;
  logic [ADDR_W-1:0] scan_idx;

  modport master (
    output mode, wr_req, wr_addr,
    input  wr_ack, wr_err, sel, scan_idx
  );

  modport slave (
    input  mode, wr_req, wr_addr,
    output wr_ack, wr_err, sel, scan_idx
  );
endinterface

// File: rtl/strobe_decoder_scan_prescaler.sv
// Scan-slot prescaler: counts 0..SCAN_DIV-1, flags the terminal count and
// the blanking window at the end of each slot.
module scan_prescaler #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  output logic tick_o,
  output logic blank_o
);
  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Terminal count and blanking window, compared at 32 bits so that a
  // threshold equal to SCAN_DIV (no blanking) cannot alias to zero.
  always_comb begin
    tick_o  = !clear_i && (32'(cnt_q) == 32'(SCAN_DIV - 1));
    blank_o = (32'(cnt_q) >= 32'(SCAN_DIV - BLANK_CYC));
  end

  // Next count: cleared on request, wraps after the terminal count.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/strobe_decoder.sv
// Registered write-strobe decoder with rotating scan mode.
// Optional build macro STROBE_DECODER_BLANK_EN: blanks sel for the last
// BLANK_CYC cycles of each scan slot.
module strobe_decoder
  import strobe_decoder_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int OUT_N     = 16,
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  strobe_decoder_if.slave   bus
);

`ifdef STROBE_DECODER_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  dec_state_e        state_q, state_d;
  logic [OUT_N-1:0]  sel_q, sel_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              switch_w;
  logic              clear_w;
  logic              tick_w;
  logic              blank_w;

  scan_prescaler #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear_w),
    .tick_o  (tick_w),
    .blank_o (blank_w)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WRITE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: follow the sampled mode input.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_WRITE: if (bus.mode == MODE_SCAN)  state_d = ST_SCAN;
      ST_SCAN:  if (bus.mode == MODE_WRITE) state_d = ST_WRITE;
      default:  state_d = ST_WRITE;
    endcase
  end

  // Output decode. A mode switch wins over a request and yields one idle
  // cycle; in scan, sel follows the index one cycle behind so each select
  // line gets a full SCAN_DIV-cycle slot.
  always_comb begin
    switch_w = (state_d != state_q);
    sel_d    = '0;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    idx_d    = idx_q;
    clear_w  = 1'b1;
    if (switch_w) begin
      idx_d = '0;
    end else if (state_q == ST_WRITE) begin
      idx_d = '0;
      if (bus.wr_req) begin
        if (int'(bus.wr_addr) < OUT_N) begin
          sel_d = OUT_N'(onehot(ONEHOT_IDX_W'(bus.wr_addr), OUT_N));
          ack_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end else begin
      clear_w = 1'b0;
      if (tick_w) begin
        idx_d = (idx_q == ADDR_W'(OUT_N - 1)) ? '0 : idx_q + ADDR_W'(1);
      end
      if (!(BLANK_EN && blank_w)) begin
        sel_d = OUT_N'(onehot(ONEHOT_IDX_W'(idx_q), OUT_N));
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      idx_q <= '0;
    end else begin
      sel_q <= sel_d;
      ack_q <= ack_d;
      err_q <= err_d;
      idx_q <= idx_d;
    end
  end

  assign bus.sel      = sel_q;
  assign bus.wr_ack   = ack_q;
  assign bus.wr_err   = err_q;
  assign bus.scan_idx = idx_q;
endmodule

// File: tb/tb_strobe_decoder.sv
// Self-checking bench for strobe_decoder: two instances (OUT_N=16/SCAN_DIV=3
// and OUT_N=10/SCAN_DIV=4) share stimulus and are compared every cycle
// against a slot-arithmetic reference model.
module tb_strobe_decoder;
  import strobe_decoder_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       tb_mode = 1'b0;
  logic       tb_req  = 1'b0;
  logic [3:0] tb_addr = 4'd0;

  strobe_decoder_if #(.ADDR_W(4), .OUT_N(16)) if16 ();
  strobe_decoder_if #(.ADDR_W(4), .OUT_N(10)) if10 ();

  assign if16.mode    = tb_mode;
  assign if16.wr_req  = tb_req;
  assign if16.wr_addr = tb_addr;
  assign if10.mode    = tb_mode;
  assign if10.wr_req  = tb_req;
  assign if10.wr_addr = tb_addr;

  strobe_decoder #(.ADDR_W(4), .OUT_N(16), .SCAN_DIV(3), .BLANK_CYC(1)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(if16));
  strobe_decoder #(.ADDR_W(4), .OUT_N(10), .SCAN_DIV(4), .BLANK_CYC(1)) dut10 (
    .clk(clk), .rst_n(rst_n), .bus(if10));

`ifdef STROBE_DECODER_BLANK_EN
  localparam bit M_BLANK = 1'b1;
`else
  localparam bit M_BLANK = 1'b0;
`endif
  localparam int NN[2]  = '{16, 10};
  localparam int DIV[2] = '{3, 4};
  localparam int BLK    = 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: scan mode flag and edges elapsed since scan entry.
  bit          m_scan [2];
  int          m_k    [2];
  logic [15:0] e_sel  [2];
  logic        e_ack  [2];
  logic        e_err  [2];
  logic [3:0]  e_idx  [2];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_scan[i] = 1'b0; m_k[i] = 0;
      e_sel[i] = '0; e_ack[i] = 1'b0; e_err[i] = 1'b0; e_idx[i] = '0;
    end
  endtask

  // Outputs expected after a sampling edge with the current tb inputs.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      e_sel[i] = '0; e_ack[i] = 1'b0; e_err[i] = 1'b0;
      if (tb_mode != m_scan[i]) begin
        m_scan[i] = tb_mode; m_k[i] = 0; e_idx[i] = '0;
      end else if (!m_scan[i]) begin
        e_idx[i] = '0;
        if (tb_req) begin
          if (int'(tb_addr) < NN[i]) begin
            e_sel[i] = 16'(1) << tb_addr;
            e_ack[i] = 1'b1;
          end else begin
            e_err[i] = 1'b1;
          end
        end
      end else begin
        int slot, ph;
        m_k[i]++;
        e_idx[i] = 4'((m_k[i] / DIV[i]) % NN[i]);
        slot = ((m_k[i] - 1) / DIV[i]) % NN[i];
        ph   = (m_k[i] - 1) % DIV[i];
        if (!(M_BLANK && ph >= DIV[i] - BLK)) e_sel[i] = 16'(1) << slot;
      end
    end
  endtask

  task automatic check_all();
    chk("sel16", if16.sel, e_sel[0]);
    chk("ack16", 16'(if16.wr_ack), 16'(e_ack[0]));
    chk("err16", 16'(if16.wr_err), 16'(e_err[0]));
    chk("idx16", 16'(if16.scan_idx), 16'(e_idx[0]));
    chk("onehot16", 16'($countones(if16.sel) <= 1), 16'd1);
    chk("sel10", {6'b0, if10.sel}, e_sel[1]);
    chk("ack10", 16'(if10.wr_ack), 16'(e_ack[1]));
    chk("err10", 16'(if10.wr_err), 16'(e_err[1]));
    chk("idx10", 16'(if10.scan_idx), 16'(e_idx[1]));
    chk("onehot10", 16'($countones(if10.sel) <= 1), 16'd1);
  endtask

  task automatic step(input logic md, input logic rq, input logic [3:0] a);
    tb_mode = md; tb_req = rq; tb_addr = a;
    @(posedge clk);
    model_edge();
    #1;
    $display("step mode=%0b req=%0b addr=%0d | sel16=%h sel10=%h ack=%0b/%0b err=%0b/%0b idx=%0d/%0d",
             md, rq, a, if16.sel, if10.sel, if16.wr_ack, if10.wr_ack,
             if16.wr_err, if10.wr_err, if16.scan_idx, if10.scan_idx);
    check_all();
  endtask

  initial begin
    logic md;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    #2 rst_n = 1'b1;
    step(MODE_WRITE, 1'b0, 4'd0);

    // Back-to-back writes 0, 7, 15 (15 is out of range for OUT_N=10).
    step(MODE_WRITE, 1'b1, 4'd0);
    step(MODE_WRITE, 1'b1, 4'd7);
    step(MODE_WRITE, 1'b1, 4'd15);
    step(MODE_WRITE, 1'b0, 4'd0);
    chk("sel16_after_burst", if16.sel, 16'h0000);

    // Out-of-range address 12 then address 9.
    step(MODE_WRITE, 1'b1, 4'd12);
    step(MODE_WRITE, 1'b1, 4'd9);
    chk("sel10_addr9", {6'b0, if10.sel}, 16'h0200);
    step(MODE_WRITE, 1'b0, 4'd0);

    // Mode switch together with a request: request dropped.
    step(MODE_SCAN, 1'b1, 4'd3);
    chk("ack_on_switch", 16'(if16.wr_ack), 16'd0);
    step(MODE_SCAN, 1'b0, 4'd0);
    chk("sel10_scan_first", {6'b0, if10.sel}, 16'h0001);

    // Scan for more than a full rotation with random ignored requests.
    for (int j = 0; j < 48; j++) step(MODE_SCAN, 1'($urandom_range(0, 1)), 4'($urandom));

    // Back to write, re-enter scan and reset asynchronously at scan_idx 5.
    step(MODE_WRITE, 1'b0, 4'd0);
    step(MODE_SCAN, 1'b0, 4'd0);
    for (int j = 0; j < 100 && e_idx[1] != 4'd5; j++) step(MODE_SCAN, 1'b0, 4'd0);
    chk("idx10_before_reset", 16'(if10.scan_idx), 16'd5);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    tb_mode = MODE_WRITE;
    @(posedge clk);
    #1 check_all();
    #2 rst_n = 1'b1;
    step(MODE_WRITE, 1'b1, 4'd3);
    chk("sel16_after_reset", if16.sel, 16'h0008);

    // Random traffic with occasional mode switches.
    md = MODE_WRITE;
    for (int j = 0; j < 400; j++) begin
      if ($urandom_range(0, 19) == 0) md = ~md;
      step(md, 1'($urandom_range(0, 1)), 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
